// File: rtl/global_mem_arbiter_if.sv
// Core-array / global-memory bus bundle for global_mem_arbiter.
// The slave modport is the arbiter; the master modport is its surroundings.
interface global_mem_arbiter_if #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
);
   localparam int IW = $clog2(NUM_CORES);

   logic [NUM_CORES-1:0]        coreReadReq;
   logic [NUM_CORES-1:0]        coreWriteReq;
   logic [NUM_CORES*ADDR_W-1:0] coreAddr;
   logic [NUM_CORES*DATA_W-1:0] coreWrData;
   logic [NUM_CORES-1:0]        coreReadDone;
   logic [NUM_CORES-1:0]        coreWriteDone;
   logic [DATA_W-1:0]           coreRdData;
   logic                        memRead;
   logic                        memWrite;
   logic [ADDR_W-1:0]           memAddr;
   logic [DATA_W-1:0]           memWrData;
   logic                        memAck;
   logic [DATA_W-1:0]           memRdData;
   logic                        busy;
   logic [IW-1:0]               grantIdx;

   modport slave (
      input  coreReadReq, coreWriteReq, coreAddr, coreWrData,
      input  memAck, memRdData,
      output coreReadDone, coreWriteDone, coreRdData,
      output memRead, memWrite, memAddr, memWrData,
      output busy, grantIdx
   );

   modport master (
      output coreReadReq, coreWriteReq, coreAddr, coreWrData,
      output memAck, memRdData,
      input  coreReadDone, coreWriteDone, coreRdData,
      input  memRead, memWrite, memAddr, memWrData,
      input  busy, grantIdx
   );
endinterface

// File: rtl/global_mem_arbiter.sv
// Round-robin arbiter sharing one global-memory port between gpu cores.
// One transaction at a time: IDLE (arbitrate) -> ISSUE -> RESPOND.
module global_mem_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic                 clk,
   input  logic                 resetN,
   global_mem_arbiter_if.slave  bus
);
   localparam int IW = $clog2(NUM_CORES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t               state, nxt;
   logic [IW-1:0]        rrPtr, grantIdx, pick, cand;
   logic                 found, opRead;
   logic [NUM_CORES-1:0] req, grantOh;
   logic [ADDR_W-1:0]    memAddr;
   logic [DATA_W-1:0]    memWrData, rdData;
   int                   j;

   assign req = bus.coreReadReq | bus.coreWriteReq;

   // Scan starts just after the last winner, so it has lowest priority.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      j     = 0;
      for (int k = 1; k <= NUM_CORES; k++) begin
         j    = (int'(rrPtr) + k) % NUM_CORES;
         cand = IW'(j);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (found) nxt = ISSUE;
         ISSUE:   if (bus.memAck) nxt = RESPOND;
         RESPOND: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rrPtr     <= IW'(NUM_CORES - 1);
         grantIdx  <= '0;
         memAddr   <= '0;
         memWrData <= '0;
         rdData    <= '0;
         opRead    <= 1'b0;
      end else begin
         if (state == IDLE && found) begin
            rrPtr     <= pick;
            grantIdx  <= pick;
            memAddr   <= bus.coreAddr[int'(pick)*ADDR_W +: ADDR_W];
            memWrData <= bus.coreWrData[int'(pick)*DATA_W +: DATA_W];
            opRead    <= bus.coreReadReq[pick];
         end
         if (state == ISSUE && bus.memAck && opRead)
            rdData <= bus.memRdData;
      end
   end

   assign grantOh = NUM_CORES'(1) << grantIdx;

   assign bus.memRead       = (state == ISSUE) && opRead;
   assign bus.memWrite      = (state == ISSUE) && !opRead;
   assign bus.memAddr       = memAddr;
   assign bus.memWrData     = memWrData;
   assign bus.coreRdData    = rdData;
   assign bus.busy          = (state != IDLE);
   assign bus.grantIdx      = grantIdx;
   assign bus.coreReadDone  =
      (state == RESPOND && opRead) ? grantOh : '0;
   assign bus.coreWriteDone =
      (state == RESPOND && !opRead) ? grantOh : '0;
endmodule

// File: tb/tb_global_mem_arbiter.sv
// Directed bench for global_mem_arbiter.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_global_mem_arbiter;
   logic clk = 1'b0;
   logic resetN;
   int   n_cmp = 0;
   int   n_bad = 0;

   global_mem_arbiter_if #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32)) bus ();

   global_mem_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      resetN           = 1'b0;
      bus.coreReadReq  = '0;
      bus.coreWriteReq = '0;
      bus.coreAddr     = '0;
      bus.coreWrData   = '0;
      bus.memAck       = 1'b0;
      bus.memRdData    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_memRead", 64'(bus.memRead), 64'(0));
      chk("rst_memWrite", 64'(bus.memWrite), 64'(0));
      chk("rst_grant", 64'(bus.grantIdx), 64'(0));
      chk("rst_addr", 64'(bus.memAddr), 64'(0));
      chk("rst_rdata", 64'(bus.coreRdData), 64'(0));
      resetN = 1'b1;
      tick();

      // single read from core 2
      bus.coreAddr[2*32 +: 32] = 32'h100;
      bus.coreReadReq = 4'b0100;
      tick();
      chk("t1_grant", 64'(bus.grantIdx), 64'(2));
      chk("t1_memRead", 64'(bus.memRead), 64'(1));
      chk("t1_addr", 64'(bus.memAddr), 64'h100);
      chk("t1_nodone", 64'(bus.coreReadDone), 64'(0));
      repeat (3) tick();
      chk("t1_hold", 64'(bus.memRead), 64'(1));
      bus.memAck = 1'b1;
      bus.memRdData = 32'hDEADBEEF;
      tick();
      bus.memAck = 1'b0;
      bus.memRdData = '0;
      chk("t1_done", 64'(bus.coreReadDone), 64'(4'b0100));
      chk("t1_rdata", 64'(bus.coreRdData), 64'hDEADBEEF);
      chk("t1_strobe_off", 64'(bus.memRead), 64'(0));
      bus.coreReadReq = '0;
      tick();
      chk("t1_pulse1", 64'(bus.coreReadDone), 64'(0));
      chk("t1_rdata_hold", 64'(bus.coreRdData), 64'hDEADBEEF);
      chk("t1_idle", 64'(bus.busy), 64'(0));

      // single write from core 1
      bus.coreAddr[1*32 +: 32]   = 32'h40;
      bus.coreWrData[1*32 +: 32] = 32'h12345678;
      bus.coreWriteReq = 4'b0010;
      tick();
      chk("t2_grant", 64'(bus.grantIdx), 64'(1));
      chk("t2_memWrite", 64'(bus.memWrite), 64'(1));
      chk("t2_memRead", 64'(bus.memRead), 64'(0));
      chk("t2_wdata", 64'(bus.memWrData), 64'h12345678);
      chk("t2_addr", 64'(bus.memAddr), 64'h40);
      chk("t2_nodone", 64'(bus.coreWriteDone), 64'(0));
      bus.memAck = 1'b1;
      tick();
      bus.memAck = 1'b0;
      chk("t2_done", 64'(bus.coreWriteDone), 64'(4'b0010));
      chk("t2_nordone", 64'(bus.coreReadDone), 64'(0));
      chk("t2_rdata_keep", 64'(bus.coreRdData), 64'hDEADBEEF);
      bus.coreWriteReq = '0;
      tick();
      chk("t2_pulse1", 64'(bus.coreWriteDone), 64'(0));

      // round robin with all cores requesting, after a fresh reset
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      for (int i = 0; i < 4; i++)
         bus.coreAddr[i*32 +: 32] = 32'h1000 + 32'(i*4);
      bus.coreReadReq = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("t3_grant%0d", k), 64'(bus.grantIdx), 64'(k % 4));
         chk($sformatf("t3_addr%0d", k), 64'(bus.memAddr),
             64'(32'h1000 + 32'((k % 4) * 4)));
         bus.memAck = 1'b1;
         bus.memRdData = 32'hA0000000 + 32'(k);
         tick();
         bus.memAck = 1'b0;
         chk($sformatf("t3_done%0d", k), 64'(bus.coreReadDone),
             64'(4'b0001 << (k % 4)));
         chk($sformatf("t3_rdata%0d", k), 64'(bus.coreRdData),
             64'(32'hA0000000 + 32'(k)));
         tick();
      end
      bus.coreReadReq = '0;

      // read and write both set on core 3: read wins
      bus.coreAddr[3*32 +: 32]   = 32'h300;
      bus.coreWrData[3*32 +: 32] = 32'h55;
      bus.coreReadReq  = 4'b1000;
      bus.coreWriteReq = 4'b1000;
      tick();
      chk("t4_grant", 64'(bus.grantIdx), 64'(3));
      chk("t4_memRead", 64'(bus.memRead), 64'(1));
      chk("t4_memWrite", 64'(bus.memWrite), 64'(0));
      bus.memAck = 1'b1;
      bus.memRdData = 32'hCAFE0003;
      tick();
      bus.memAck = 1'b0;
      chk("t4_rdone", 64'(bus.coreReadDone), 64'(4'b1000));
      chk("t4_wdone", 64'(bus.coreWriteDone), 64'(0));
      chk("t4_memWrite2", 64'(bus.memWrite), 64'(0));
      chk("t4_rdata", 64'(bus.coreRdData), 64'hCAFE0003);
      bus.coreReadReq  = '0;
      bus.coreWriteReq = '0;
      tick();

      // async reset during ISSUE
      bus.coreReadReq = 4'b0010;
      tick();
      chk("t5_issue", 64'(bus.memRead), 64'(1));
      chk("t5_busy", 64'(bus.busy), 64'(1));
      #2;
      resetN = 1'b0;
      #1;
      chk("t5_rst_memRead", 64'(bus.memRead), 64'(0));
      chk("t5_rst_busy", 64'(bus.busy), 64'(0));
      chk("t5_rst_done", 64'(bus.coreReadDone), 64'(0));
      chk("t5_rst_grant", 64'(bus.grantIdx), 64'(0));
      bus.coreReadReq = '0;
      tick();
      tick();
      chk("t5_rst_nodone", 64'(bus.coreReadDone | bus.coreWriteDone), 64'(0));
      resetN = 1'b1;
      bus.coreReadReq = 4'b0011;
      tick();
      chk("t5_first", 64'(bus.grantIdx), 64'(0));
      chk("t5_first_addr", 64'(bus.memAddr), 64'h1000);
      bus.memAck = 1'b1;
      bus.memRdData = 32'h5A5A0000;
      tick();
      bus.memAck = 1'b0;
      chk("t5_done0", 64'(bus.coreReadDone), 64'(4'b0001));
      bus.coreReadReq = 4'b0010;
      tick();
      tick();
      chk("t5_second", 64'(bus.grantIdx), 64'(1));
      bus.memAck = 1'b1;
      bus.memRdData = 32'h5A5A0001;
      tick();
      bus.memAck = 1'b0;
      chk("t5_done1", 64'(bus.coreReadDone), 64'(4'b0010));
      chk("t5_rdata", 64'(bus.coreRdData), 64'h5A5A0001);
      bus.coreReadReq = '0;
      tick();

      // stray memAck while idle
      bus.memAck = 1'b1;
      bus.memRdData = 32'hBAD0BAD0;
      tick();
      chk("t6_done", 64'(bus.coreReadDone | bus.coreWriteDone), 64'(0));
      chk("t6_busy", 64'(bus.busy), 64'(0));
      chk("t6_rdata", 64'(bus.coreRdData), 64'h5A5A0001);
      chk("t6_strobe", 64'(bus.memRead | bus.memWrite), 64'(0));
      bus.memAck = 1'b0;
      tick();
      chk("t6_done2", 64'(bus.coreReadDone | bus.coreWriteDone), 64'(0));
      chk("t6_busy2", 64'(bus.busy), 64'(0));
      chk("t6_rdata2", 64'(bus.coreRdData), 64'h5A5A0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
